bus_arbiter: RTL and testbench

Shares one downstream bus/MMU port between the core's fetch requester and its memory requester. Holds one pending request per requester and issues one transaction at a time. Routes the downstream response, or MMU exception, back to the requester that owns the transaction. Sits between the core's fetch/mem bus ports and the MMU/memory port.

---
 rtl/bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester arbiter sharing one downstream bus/MMU port
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int POLICY = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                f_req,
    input  logic                f_mode,
    input  logic [ADDR_W-1:0]   f_addr,
    input  logic [DATA_W-1:0]   f_wdata,
    input  logic [DATA_W/8-1:0] f_wstrb,
    output logic                f_resp,
    output logic [DATA_W-1:0]   f_rdata,
    output logic                f_exc,
    output logic [4:0]          f_exc_vec,
    output logic [31:0]         f_exc_tval,
    input  logic                m_req,
    input  logic                m_mode,
    input  logic [ADDR_W-1:0]   m_addr,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_resp,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                m_exc,
    output logic [4:0]          m_exc_vec,
    output logic [31:0]         m_exc_tval,
    output logic                d_req,
    output logic                d_mode,
    output logic [ADDR_W-1:0]   d_addr,
    output logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W/8-1:0] d_wstrb,
    input  logic                d_resp,
    input  logic [DATA_W-1:0]   d_rdata,
    input  logic                d_exc,
    input  logic [4:0]          d_exc_vec,
    input  logic [31:0]         d_exc_tval
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {FETCH, MEM} src_t;

    state_t state, state_nx;
    src_t   owner, last_grant;

    logic              f_pend, m_pend;
    logic              f_p_mode, m_p_mode;
    logic [ADDR_W-1:0] f_p_addr, m_p_addr;
    logic [DATA_W-1:0] f_p_wdata, m_p_wdata;
    logic [STRB_W-1:0] f_p_wstrb, m_p_wstrb;

    logic              busy;
    logic              f_acc, m_acc;
    logic              f_cand, m_cand;
    logic              grant_f, grant_m;
    logic              g_mode;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;
    logic              done;

    // A pulse is accepted only if its slot is free and it does not own the in-flight transfer.
    assign busy   = (state == BUSY);
    assign f_acc  = f_req & ~f_pend & ~(busy & (owner == FETCH));
    assign m_acc  = m_req & ~m_pend & ~(busy & (owner == MEM));
    assign f_cand = ~busy & (f_pend | f_acc);
    assign m_cand = ~busy & (m_pend | m_acc);
    assign done   = busy & (d_resp | d_exc);

    always_comb begin
        state_nx = state;
        grant_f  = 1'b0;
        grant_m  = 1'b0;
        case (state)
            IDLE: begin
                if (f_cand && m_cand) begin
                    if (POLICY == 1) begin
                        grant_m = 1'b1;
                    end else if (last_grant == MEM) begin
                        grant_f = 1'b1;
                    end else begin
                        grant_m = 1'b1;
                    end
                end else begin
                    grant_f = f_cand;
                    grant_m = m_cand;
                end
                if (grant_f || grant_m) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (d_resp || d_exc) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Granted fields come from the pending slot, or straight from the inputs when bypassing it.
    always_comb begin
        g_mode  = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        if (grant_m) begin
            g_mode  = m_pend ? m_p_mode  : m_mode;
            g_addr  = m_pend ? m_p_addr  : m_addr;
            g_wdata = m_pend ? m_p_wdata : m_wdata;
            g_wstrb = m_pend ? m_p_wstrb : m_wstrb;
        end else if (grant_f) begin
            g_mode  = f_pend ? f_p_mode  : f_mode;
            g_addr  = f_pend ? f_p_addr  : f_addr;
            g_wdata = f_pend ? f_p_wdata : f_wdata;
            g_wstrb = f_pend ? f_p_wstrb : f_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            owner      <= FETCH;
            last_grant <= MEM;
            f_pend     <= 1'b0;
            m_pend     <= 1'b0;
            f_p_mode   <= 1'b0;
            f_p_addr   <= '0;
            f_p_wdata  <= '0;
            f_p_wstrb  <= '0;
            m_p_mode   <= 1'b0;
            m_p_addr   <= '0;
            m_p_wdata  <= '0;
            m_p_wstrb  <= '0;
            d_req      <= 1'b0;
            d_mode     <= 1'b0;
            d_addr     <= '0;
            d_wdata    <= '0;
            d_wstrb    <= '0;
            f_resp     <= 1'b0;
            f_rdata    <= '0;
            f_exc      <= 1'b0;
            f_exc_vec  <= '0;
            f_exc_tval <= '0;
            m_resp     <= 1'b0;
            m_rdata    <= '0;
            m_exc      <= 1'b0;
            m_exc_vec  <= '0;
            m_exc_tval <= '0;
        end else begin
            state  <= state_nx;
            d_req  <= 1'b0;
            f_resp <= 1'b0;
            f_exc  <= 1'b0;
            m_resp <= 1'b0;
            m_exc  <= 1'b0;

            if (grant_f) begin
                f_pend <= 1'b0;
            end else if (f_acc) begin
                f_pend    <= 1'b1;
                f_p_mode  <= f_mode;
                f_p_addr  <= f_addr;
                f_p_wdata <= f_wdata;
                f_p_wstrb <= f_wstrb;
            end

            if (grant_m) begin
                m_pend <= 1'b0;
            end else if (m_acc) begin
                m_pend    <= 1'b1;
                m_p_mode  <= m_mode;
                m_p_addr  <= m_addr;
                m_p_wdata <= m_wdata;
                m_p_wstrb <= m_wstrb;
            end

            if (grant_f || grant_m) begin
                d_req      <= 1'b1;
                d_mode     <= g_mode;
                d_addr     <= g_addr;
                d_wdata    <= g_wdata;
                d_wstrb    <= g_wstrb;
                owner      <= grant_m ? MEM : FETCH;
                last_grant <= grant_m ? MEM : FETCH;
            end

            // An exception suppresses the normal response and leaves rdata untouched.
            if (done) begin
                if (owner == FETCH) begin
                    if (d_exc) begin
                        f_exc      <= 1'b1;
                        f_exc_vec  <= d_exc_vec;
                        f_exc_tval <= d_exc_tval;
                    end else begin
                        f_resp  <= 1'b1;
                        f_rdata <= d_rdata;
                    end
                end else begin
                    if (d_exc) begin
                        m_exc      <= 1'b1;
                        m_exc_vec  <= d_exc_vec;
                        m_exc_tval <= d_exc_tval;
                    end else begin
                        m_resp  <= 1'b1;
                        m_rdata <= d_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter (round-robin and mem-priority)
module tb_bus_arbiter;

    logic        clk;
    logic        rstn;
    logic        f_req, f_mode, m_req, m_mode;
    logic [31:0] f_addr, f_wdata, m_addr, m_wdata;
    logic [3:0]  f_wstrb, m_wstrb;
    logic        d_resp, d_exc;
    logic [31:0] d_rdata, d_exc_tval;
    logic [4:0]  d_exc_vec;

    logic        f_resp_0, f_exc_0, m_resp_0, m_exc_0, d_req_0, d_mode_0;
    logic [31:0] f_rdata_0, f_exc_tval_0, m_rdata_0, m_exc_tval_0, d_addr_0, d_wdata_0;
    logic [4:0]  f_exc_vec_0, m_exc_vec_0;
    logic [3:0]  d_wstrb_0;

    logic        f_resp_1, f_exc_1, m_resp_1, m_exc_1, d_req_1, d_mode_1;
    logic [31:0] f_rdata_1, f_exc_tval_1, m_rdata_1, m_exc_tval_1, d_addr_1, d_wdata_1;
    logic [4:0]  f_exc_vec_1, m_exc_vec_1;
    logic [3:0]  d_wstrb_1;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .POLICY(0)) u0 (
        .clk(clk), .rstn(rstn),
        .f_req(f_req), .f_mode(f_mode), .f_addr(f_addr), .f_wdata(f_wdata), .f_wstrb(f_wstrb),
        .f_resp(f_resp_0), .f_rdata(f_rdata_0), .f_exc(f_exc_0),
        .f_exc_vec(f_exc_vec_0), .f_exc_tval(f_exc_tval_0),
        .m_req(m_req), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp(m_resp_0), .m_rdata(m_rdata_0), .m_exc(m_exc_0),
        .m_exc_vec(m_exc_vec_0), .m_exc_tval(m_exc_tval_0),
        .d_req(d_req_0), .d_mode(d_mode_0), .d_addr(d_addr_0), .d_wdata(d_wdata_0),
        .d_wstrb(d_wstrb_0),
        .d_resp(d_resp), .d_rdata(d_rdata), .d_exc(d_exc),
        .d_exc_vec(d_exc_vec), .d_exc_tval(d_exc_tval)
    );

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .POLICY(1)) u1 (
        .clk(clk), .rstn(rstn),
        .f_req(f_req), .f_mode(f_mode), .f_addr(f_addr), .f_wdata(f_wdata), .f_wstrb(f_wstrb),
        .f_resp(f_resp_1), .f_rdata(f_rdata_1), .f_exc(f_exc_1),
        .f_exc_vec(f_exc_vec_1), .f_exc_tval(f_exc_tval_1),
        .m_req(m_req), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp(m_resp_1), .m_rdata(m_rdata_1), .m_exc(m_exc_1),
        .m_exc_vec(m_exc_vec_1), .m_exc_tval(m_exc_tval_1),
        .d_req(d_req_1), .d_mode(d_mode_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_wstrb(d_wstrb_1),
        .d_resp(d_resp), .d_rdata(d_rdata), .d_exc(d_exc),
        .d_exc_vec(d_exc_vec), .d_exc_tval(d_exc_tval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within 100000 time units");
        $fatal(1);
    end

    typedef struct packed {
        logic        rn;
        logic        fr;
        logic [31:0] fa;
        logic        mr;
        logic [31:0] ma;
        logic        mm;
        logic        dr;
        logic        de;
        logic [31:0] dd;
        logic [4:0]  vv;
        logic        e_dreq;
        logic [31:0] e_daddr;
        logic        e_dmode;
        logic        e_fresp;
        logic        e_fexc;
        logic [31:0] e_frdata;
        logic        e_mresp;
        logic        e_mexc;
        logic [31:0] e_mrdata;
        logic [4:0]  e_mvec;
        logic [31:0] e_mtval;
    } vec_t;

    vec_t tbl [64];
    int   n_vec;

    function automatic vec_t mk(
        input logic rn, input logic fr, input logic [31:0] fa,
        input logic mr, input logic [31:0] ma, input logic mm,
        input logic dr, input logic de, input logic [31:0] dd, input logic [4:0] vv,
        input logic e_dreq, input logic [31:0] e_daddr, input logic e_dmode,
        input logic e_fresp, input logic e_fexc, input logic [31:0] e_frdata,
        input logic e_mresp, input logic e_mexc, input logic [31:0] e_mrdata,
        input logic [4:0] e_mvec, input logic [31:0] e_mtval);
        vec_t v;
        v.rn = rn; v.fr = fr; v.fa = fa; v.mr = mr; v.ma = ma; v.mm = mm;
        v.dr = dr; v.de = de; v.dd = dd; v.vv = vv;
        v.e_dreq = e_dreq; v.e_daddr = e_daddr; v.e_dmode = e_dmode;
        v.e_fresp = e_fresp; v.e_fexc = e_fexc; v.e_frdata = e_frdata;
        v.e_mresp = e_mresp; v.e_mexc = e_mexc; v.e_mrdata = e_mrdata;
        v.e_mvec = e_mvec; v.e_mtval = e_mtval;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        f_req = 1'b0; m_req = 1'b0; d_resp = 1'b0; d_exc = 1'b0;
    endtask

    task automatic add(input vec_t v);
        tbl[n_vec] = v;
        n_vec++;
    endtask

    initial begin
        rstn = 1'b0;
        f_req = 1'b0; f_mode = 1'b0; f_addr = '0; f_wdata = 32'h1111_2222; f_wstrb = 4'hF;
        m_req = 1'b0; m_mode = 1'b0; m_addr = '0; m_wdata = 32'h3333_4444; m_wstrb = 4'h3;
        d_resp = 1'b0; d_exc = 1'b0; d_rdata = '0; d_exc_vec = '0; d_exc_tval = '0;
        n_vec = 0;

        //   rn fr fa           mr ma           mm dr de dd           vv | dq daddr        dm fr fe frdata       mr me mrdata       mv mtval
        add(mk(0, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 0,           0, 0, 0, 0,           0, 0, 0,           0, 0));
        add(mk(0, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 0,           0, 0, 0, 0,           0, 0, 0,           0, 0));
        add(mk(1, 1, 32'h2000,   1, 32'h3000,    1, 0, 0, 0,           0,  1, 32'h2000,    0, 0, 0, 0,           0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h2000,    0, 0, 0, 0,           0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'h11,      0,  0, 32'h2000,    0, 1, 0, 32'h11,      0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  1, 32'h3000,    1, 0, 0, 32'h11,      0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h3000,    1, 0, 0, 32'h11,      0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'h22,      0,  0, 32'h3000,    1, 0, 0, 32'h11,      1, 0, 32'h22,      0, 0));
        add(mk(1, 1, 32'h4000,   1, 32'h5000,    0, 0, 0, 0,           0,  1, 32'h4000,    0, 0, 0, 32'h11,      0, 0, 32'h22,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h4000,    0, 0, 0, 32'h11,      0, 0, 32'h22,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'h33,      0,  0, 32'h4000,    0, 1, 0, 32'h33,      0, 0, 32'h22,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  1, 32'h5000,    0, 0, 0, 32'h33,      0, 0, 32'h22,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h5000,    0, 0, 0, 32'h33,      0, 0, 32'h22,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'h44,      0,  0, 32'h5000,    0, 0, 0, 32'h33,      1, 0, 32'h44,      0, 0));
        // single fetch read, response five cycles after the request
        add(mk(1, 1, 32'h1000,   0, 0,           0, 0, 0, 0,           0,  1, 32'h1000,    0, 0, 0, 32'h33,      0, 0, 32'h44,      0, 0));
        for (int i = 0; i < 4; i++)
            add(mk(1, 0, 0,      0, 0,           0, 0, 0, 0,           0,  0, 32'h1000,    0, 0, 0, 32'h33,      0, 0, 32'h44,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'hDEADBEEF,0,  0, 32'h1000,    0, 1, 0, 32'hDEADBEEF,0, 0, 32'h44,      0, 0));
        // last grant was fetch, so this tie goes to mem; repeated pulses are dropped
        add(mk(1, 1, 32'h6000,   1, 32'h7000,    1, 0, 0, 0,           0,  1, 32'h7000,    1, 0, 0, 32'hDEADBEEF,0, 0, 32'h44,      0, 0));
        add(mk(1, 1, 32'h6100,   0, 0,           0, 0, 0, 0,           0,  0, 32'h7000,    1, 0, 0, 32'hDEADBEEF,0, 0, 32'h44,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'h55,      0,  0, 32'h7000,    1, 0, 0, 32'hDEADBEEF,1, 0, 32'h55,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  1, 32'h6000,    0, 0, 0, 32'hDEADBEEF,0, 0, 32'h55,      0, 0));
        add(mk(1, 1, 32'h6200,   0, 0,           0, 0, 0, 0,           0,  0, 32'h6000,    0, 0, 0, 32'hDEADBEEF,0, 0, 32'h55,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'h66,      0,  0, 32'h6000,    0, 1, 0, 32'h66,      0, 0, 32'h55,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h6000,    0, 0, 0, 32'h66,      0, 0, 32'h55,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'h77,      0,  0, 32'h6000,    0, 0, 0, 32'h66,      0, 0, 32'h55,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h6000,    0, 0, 0, 32'h66,      0, 0, 32'h55,      0, 0));
        // exception routing, then exception together with response
        add(mk(1, 0, 0,          1, 32'h80000004,1, 0, 0, 0,           0,  1, 32'h80000004,1, 0, 0, 32'h66,      0, 0, 32'h55,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 1, 32'h80000004,15, 0, 32'h80000004,1, 0, 0, 32'h66,      0, 1, 32'h55,      15, 32'h80000004));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h80000004,1, 0, 0, 32'h66,      0, 0, 32'h55,      15, 32'h80000004));
        add(mk(1, 0, 0,          1, 32'h9000,    1, 0, 0, 0,           0,  1, 32'h9000,    1, 0, 0, 32'h66,      0, 0, 32'h55,      15, 32'h80000004));
        add(mk(1, 0, 0,          0, 0,           0, 1, 1, 32'h9000,    7,  0, 32'h9000,    1, 0, 0, 32'h66,      0, 1, 32'h55,      7, 32'h9000));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'h9000,    1, 0, 0, 32'h66,      0, 0, 32'h55,      7, 32'h9000));
        // re-request in the cycle the response appears
        add(mk(1, 1, 32'hA000,   0, 0,           0, 0, 0, 0,           0,  1, 32'hA000,    0, 0, 0, 32'h66,      0, 0, 32'h55,      7, 32'h9000));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'hAA,      0,  0, 32'hA000,    0, 1, 0, 32'hAA,      0, 0, 32'h55,      7, 32'h9000));
        add(mk(1, 1, 32'hB000,   0, 0,           0, 0, 0, 0,           0,  1, 32'hB000,    0, 0, 0, 32'hAA,      0, 0, 32'h55,      7, 32'h9000));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'hBB,      0,  0, 32'hB000,    0, 1, 0, 32'hBB,      0, 0, 32'h55,      7, 32'h9000));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'hB000,    0, 0, 0, 32'hBB,      0, 0, 32'h55,      7, 32'h9000));
        // reset while busy, stale response afterwards, then a fresh mem request
        add(mk(1, 0, 0,          1, 32'hC000,    0, 0, 0, 0,           0,  1, 32'hC000,    0, 0, 0, 32'hBB,      0, 0, 32'h55,      7, 32'h9000));
        add(mk(0, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 0,           0, 0, 0, 0,           0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'hCC,      0,  0, 0,           0, 0, 0, 0,           0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          1, 32'hD000,    1, 0, 0, 0,           0,  1, 32'hD000,    1, 0, 0, 0,           0, 0, 0,           0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'hDD,      0,  0, 32'hD000,    1, 0, 0, 0,           1, 0, 32'hDD,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'hD000,    1, 0, 0, 0,           0, 0, 32'hDD,      0, 0));
        // mem request captured into its slot while fetch is in flight
        add(mk(1, 1, 32'hE000,   0, 0,           0, 0, 0, 0,           0,  1, 32'hE000,    0, 0, 0, 0,           0, 0, 32'hDD,      0, 0));
        add(mk(1, 0, 0,          1, 32'hF000,    0, 0, 0, 0,           0,  0, 32'hE000,    0, 0, 0, 0,           0, 0, 32'hDD,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'hEE,      0,  0, 32'hE000,    0, 1, 0, 32'hEE,      0, 0, 32'hDD,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  1, 32'hF000,    0, 0, 0, 32'hEE,      0, 0, 32'hDD,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 1, 0, 32'hFF,      0,  0, 32'hF000,    0, 0, 0, 32'hEE,      1, 0, 32'hFF,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 0, 0,           0,  0, 32'hF000,    0, 0, 0, 32'hEE,      0, 0, 32'hFF,      0, 0));
        // fetch exception
        add(mk(1, 1, 32'h10,     0, 0,           0, 0, 0, 0,           0,  1, 32'h10,      0, 0, 0, 32'hEE,      0, 0, 32'hFF,      0, 0));
        add(mk(1, 0, 0,          0, 0,           0, 0, 1, 32'h10,      1,  0, 32'h10,      0, 0, 1, 32'hEE,      0, 0, 32'hFF,      0, 0));

        for (int i = 0; i < n_vec; i++) begin
            rstn       = tbl[i].rn;
            f_req      = tbl[i].fr;
            f_addr     = tbl[i].fa;
            f_mode     = 1'b0;
            m_req      = tbl[i].mr;
            m_addr     = tbl[i].ma;
            m_mode     = tbl[i].mm;
            d_resp     = tbl[i].dr;
            d_exc      = tbl[i].de;
            d_rdata    = tbl[i].dd;
            d_exc_tval = tbl[i].dd;
            d_exc_vec  = tbl[i].vv;
            step();
            chk("d_req",      i, {31'd0, d_req_0},   {31'd0, tbl[i].e_dreq});
            chk("d_addr",     i, d_addr_0,           tbl[i].e_daddr);
            chk("d_mode",     i, {31'd0, d_mode_0},  {31'd0, tbl[i].e_dmode});
            chk("f_resp",     i, {31'd0, f_resp_0},  {31'd0, tbl[i].e_fresp});
            chk("f_exc",      i, {31'd0, f_exc_0},   {31'd0, tbl[i].e_fexc});
            chk("f_rdata",    i, f_rdata_0,          tbl[i].e_frdata);
            chk("m_resp",     i, {31'd0, m_resp_0},  {31'd0, tbl[i].e_mresp});
            chk("m_exc",      i, {31'd0, m_exc_0},   {31'd0, tbl[i].e_mexc});
            chk("m_rdata",    i, m_rdata_0,          tbl[i].e_mrdata);
            chk("m_exc_vec",  i, {27'd0, m_exc_vec_0}, {27'd0, tbl[i].e_mvec});
            chk("m_exc_tval", i, m_exc_tval_0,       tbl[i].e_mtval);
        end
        chk("f_exc_vec",  n_vec, {27'd0, f_exc_vec_0}, 32'd1);
        chk("f_exc_tval", n_vec, f_exc_tval_0,         32'h10);

        // mem-priority instance: ties always go to mem
        idle_inputs();
        rstn = 1'b0;
        step();
        chk("p1 reset d_req",  100, {31'd0, d_req_1},  32'd0);
        chk("p1 reset d_addr", 100, d_addr_1,          32'd0);
        rstn = 1'b1;
        f_req = 1'b1; f_addr = 32'h100; f_mode = 1'b0;
        m_req = 1'b1; m_addr = 32'h200; m_mode = 1'b1;
        step();
        chk("p1 tie d_req",   101, {31'd0, d_req_1},  32'd1);
        chk("p1 tie d_addr",  101, d_addr_1,          32'h200);
        chk("p1 tie d_mode",  101, {31'd0, d_mode_1}, 32'd1);
        chk("p1 tie d_wdata", 101, d_wdata_1,         32'h3333_4444);
        chk("p1 tie d_wstrb", 101, {28'd0, d_wstrb_1}, 32'h3);
        idle_inputs();
        step();
        chk("p1 busy d_req",  102, {31'd0, d_req_1},  32'd0);
        step();
        chk("p1 busy d_req",  103, {31'd0, d_req_1},  32'd0);
        d_resp = 1'b1; d_rdata = 32'h5A;
        step();
        chk("p1 m_resp",      104, {31'd0, m_resp_1}, 32'd1);
        chk("p1 m_rdata",     104, m_rdata_1,         32'h5A);
        chk("p1 f_resp",      104, {31'd0, f_resp_1}, 32'd0);
        idle_inputs();
        step();
        chk("p1 f d_req",     105, {31'd0, d_req_1},  32'd1);
        chk("p1 f d_addr",    105, d_addr_1,          32'h100);
        chk("p1 f d_wdata",   105, d_wdata_1,         32'h1111_2222);
        chk("p1 f d_wstrb",   105, {28'd0, d_wstrb_1}, 32'hF);
        d_resp = 1'b1; d_rdata = 32'h6B;
        step();
        chk("p1 f_resp",      106, {31'd0, f_resp_1}, 32'd1);
        chk("p1 f_rdata",     106, f_rdata_1,         32'h6B);
        idle_inputs();
        m_req = 1'b1; m_addr = 32'h300;
        step();
        chk("p1 m d_addr",    107, d_addr_1,          32'h300);
        idle_inputs();
        d_resp = 1'b1; d_rdata = 32'h7C;
        step();
        chk("p1 m_rdata",     108, m_rdata_1,         32'h7C);
        idle_inputs();
        f_req = 1'b1; f_addr = 32'h100;
        m_req = 1'b1; m_addr = 32'h200;
        step();
        chk("p1 tie2 d_req",  109, {31'd0, d_req_1},  32'd1);
        chk("p1 tie2 d_addr", 109, d_addr_1,          32'h200);
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
